// File: rtl/weight_ram_pkg.sv
// Shared types and helpers for the per-neuron weight RAM controller:
// FSM state encoding, lane geometry derivations and the saturating adder.
package weight_ram_pkg;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RMW_WR = 2'd1;
  localparam logic [1:0] S_CLEAR  = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = S_IDLE,
    RMW_WR = S_RMW_WR,
    CLEAR  = S_CLEAR
  } state_t;

  localparam int unsigned SAT_MAXW = 32;
  typedef logic signed [SAT_MAXW-1:0] sat_t;

  function automatic int unsigned lanes_of(input int unsigned width, input int unsigned weights);
    return (weights + 1) / width;
  endfunction

  function automatic int unsigned lane_w_of(input int unsigned width, input int unsigned weights);
    return (lanes_of(width, weights) > 1) ? $clog2(lanes_of(width, weights)) : 1;
  endfunction

  localparam int unsigned LANES  = lanes_of(8, 31);
  localparam int unsigned LANE_W = lane_w_of(8, 31);

  // Operands arrive already sign-extended from w bits; w+1 bits of headroom
  // are guaranteed by SAT_MAXW, so the raw sum cannot wrap before clamping.
  function automatic sat_t sat_add(input sat_t a, input sat_t b, input int unsigned w);
    sat_t sum;
    sat_t hi;
    sat_t lo;
    sat_t res;
    sum = a + b;
    hi  = sat_t'(32'h7FFF_FFFF >> (SAT_MAXW - w));
    lo  = ~hi;
    if (sum > hi)      res = hi;
    else if (sum < lo) res = lo;
    else               res = sum;
    return res;
  endfunction

endpackage

// File: rtl/weight_ram_ctrl_if.sv
// Client-side bus of the weight RAM controller: read, update and clear
// handshakes. The controller uses the slave view, clients the master view.
interface weight_ram_ctrl_if #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NEURON_ADR = 5,
  parameter int unsigned WEIGHTS    = 31
);
  import weight_ram_pkg::*;

  localparam int unsigned LW = lane_w_of(WIDTH, WEIGHTS);

  logic                  rd_req;
  logic [NEURON_ADR:0]   rd_addr;
  logic                  rd_gnt;
  logic                  rd_valid;
  logic [WEIGHTS:0]      rd_data;
  logic                  upd_req;
  logic [NEURON_ADR:0]   upd_addr;
  logic [LW-1:0]         upd_lane;
  logic [WIDTH-1:0]      upd_delta;
  logic                  upd_ack;
  logic                  clr_req;
  logic                  clr_done;

  modport slave (
    input  rd_req, rd_addr, upd_req, upd_addr, upd_lane, upd_delta, clr_req,
    output rd_gnt, rd_valid, rd_data, upd_ack, clr_done
  );

  modport master (
    output rd_req, rd_addr, upd_req, upd_addr, upd_lane, upd_delta, clr_req,
    input  rd_gnt, rd_valid, rd_data, upd_ack, clr_done
  );

endinterface

// File: rtl/weight_lane_merge.sv
// Combinational lane datapath: extracts one lane of the read word and
// saturates it against the delta, and inserts a lane into a stored word.
module weight_lane_merge
  import weight_ram_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned WEIGHTS = 31
) (
  input  logic [WEIGHTS:0]                      i_word,
  input  logic [lane_w_of(WIDTH, WEIGHTS)-1:0]  i_lane,
  input  logic [WIDTH-1:0]                      i_delta,
  output logic [WIDTH-1:0]                      o_sum,
  input  logic [WEIGHTS:0]                      i_ins_word,
  input  logic [lane_w_of(WIDTH, WEIGHTS)-1:0]  i_ins_lane,
  input  logic [WIDTH-1:0]                      i_ins_val,
  output logic [WEIGHTS:0]                      o_word
);

  localparam int unsigned N_LANES = lanes_of(WIDTH, WEIGHTS);
  localparam int unsigned LW      = lane_w_of(WIDTH, WEIGHTS);

  logic signed [WIDTH-1:0] w_lane;

  always_comb begin
    w_lane = '0;
    o_word = i_ins_word;
    for (int unsigned l = 0; l < N_LANES; l++) begin
      if (i_lane == LW'(l))     w_lane = i_word[l*WIDTH +: WIDTH];
      if (i_ins_lane == LW'(l)) o_word[l*WIDTH +: WIDTH] = i_ins_val;
    end
  end

  assign o_sum = WIDTH'(sat_add(sat_t'(w_lane), sat_t'($signed(i_delta)), WIDTH));

endmodule

// File: rtl/weight_ram_ctrl.sv
// Arbiter and sequencer in front of one per-neuron weight RAM: row reads,
// saturating lane read-modify-write, and a full zero-fill sweep.
module weight_ram_ctrl
  import weight_ram_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NEURON_ADR = 5,
  parameter int unsigned WEIGHTS    = 31,
  parameter int unsigned STARVE     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  weight_ram_ctrl_if.slave     cif,
  output logic                 busy,
  output logic                 ram_we,
  output logic [NEURON_ADR:0]  ram_a,
  output logic [WEIGHTS:0]     ram_di,
  output logic [NEURON_ADR:0]  ram_dpra,
  input  logic [WEIGHTS:0]     ram_dpo
);

  localparam int unsigned AW = NEURON_ADR + 1;
  localparam int unsigned LW = lane_w_of(WIDTH, WEIGHTS);
  localparam int unsigned SW = $clog2(STARVE + 1);
  localparam logic [AW-1:0] LAST_ADR = '1;

  state_t            r_state;
  logic [AW-1:0]     r_clr_cnt;
  logic [AW-1:0]     r_upd_addr;
  logic [WEIGHTS:0]  r_upd_word;
  logic [LW-1:0]     r_upd_lane;
  logic [WIDTH-1:0]  r_upd_sum;
  logic [SW-1:0]     r_starve;
  logic [WEIGHTS:0]  r_rd_data;
  logic              r_rd_valid;

  logic              w_idle, w_rmw, w_clear, w_starved;
  logic              w_sel_clr, w_sel_rd, w_sel_upd;
  logic [WIDTH-1:0]  w_sum;
  logic [WEIGHTS:0]  w_merged;

  // Qualifying every state decode with rst_n keeps all strobes and the RAM
  // write enable low for the whole reset pulse, not just after the next edge.
  assign w_idle    = rst_n && (r_state == IDLE);
  assign w_rmw     = rst_n && (r_state == RMW_WR);
  assign w_clear   = rst_n && (r_state == CLEAR);
  assign w_starved = (r_starve == SW'(STARVE));

  assign w_sel_clr = w_idle && cif.clr_req;
  assign w_sel_rd  = w_idle && !cif.clr_req && cif.rd_req && !(cif.upd_req && w_starved);
  assign w_sel_upd = w_idle && !cif.clr_req && cif.upd_req && (w_starved || !cif.rd_req);

  weight_lane_merge #(.WIDTH(WIDTH), .WEIGHTS(WEIGHTS)) u_merge (
    .i_word     (ram_dpo),
    .i_lane     (cif.upd_lane),
    .i_delta    (cif.upd_delta),
    .o_sum      (w_sum),
    .i_ins_word (r_upd_word),
    .i_ins_lane (r_upd_lane),
    .i_ins_val  (r_upd_sum),
    .o_word     (w_merged)
  );

  always_comb begin
    ram_dpra = '0;
    if (w_sel_rd)       ram_dpra = cif.rd_addr;
    else if (w_sel_upd) ram_dpra = cif.upd_addr;
    ram_we = w_rmw || w_clear;
    ram_a  = '0;
    if (w_rmw)          ram_a = r_upd_addr;
    else if (w_clear)   ram_a = r_clr_cnt;
    ram_di = w_rmw ? w_merged : '0;
  end

  assign cif.rd_gnt   = w_sel_rd;
  assign cif.rd_valid = r_rd_valid;
  assign cif.rd_data  = r_rd_data;
  assign cif.upd_ack  = w_rmw;
  assign cif.clr_done = w_clear && (r_clr_cnt == LAST_ADR);
  assign busy         = rst_n && (r_state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_clr_cnt  <= '0;
      r_upd_addr <= '0;
      r_upd_word <= '0;
      r_upd_lane <= '0;
      r_upd_sum  <= '0;
      r_starve   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_sel_rd;
      if (w_sel_rd) r_rd_data <= ram_dpo;

      if (!cif.upd_req || w_rmw) r_starve <= '0;
      else if (w_sel_rd)         r_starve <= r_starve + 1'b1;

      case (r_state)
        IDLE: begin
          if (w_sel_clr) begin
            r_state   <= CLEAR;
            r_clr_cnt <= '0;
          end else if (w_sel_upd) begin
            r_state    <= RMW_WR;
            r_upd_addr <= cif.upd_addr;
            r_upd_word <= ram_dpo;
            r_upd_lane <= cif.upd_lane;
            r_upd_sum  <= w_sum;
          end
        end
        RMW_WR: r_state <= IDLE;
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == LAST_ADR) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_ram_ctrl.sv
// Self-checking bench for weight_ram_ctrl: a behavioural RAM, a word-level
// reference model of the weights, directed scenarios and random traffic.
module tb_weight_ram_ctrl;

  logic        clk;
  logic        rst_n;
  logic        busy;
  logic        ram_we;
  logic [5:0]  ram_a;
  logic [31:0] ram_di;
  logic [5:0]  ram_dpra;
  logic [31:0] ram_dpo;

  logic        tb_we;
  logic [5:0]  tb_a;
  logic [31:0] tb_d;

  logic [31:0] mem   [64];
  logic [31:0] model [64];

  int n_checks = 0;
  int n_errors = 0;

  weight_ram_ctrl_if #(.WIDTH(8), .NEURON_ADR(5), .WEIGHTS(31)) cif ();

  weight_ram_ctrl #(.WIDTH(8), .NEURON_ADR(5), .WEIGHTS(31), .STARVE(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cif      (cif),
    .busy     (busy),
    .ram_we   (ram_we),
    .ram_a    (ram_a),
    .ram_di   (ram_di),
    .ram_dpra (ram_dpra),
    .ram_dpo  (ram_dpo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (ram_we)     mem[ram_a] <= ram_di;
    else if (tb_we) mem[tb_a]  <= tb_d;
  end
  assign ram_dpo = mem[ram_dpra];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: lane value plus delta as integers, clamped to the int8 range.
  function automatic logic [31:0] model_upd(input logic [31:0] w, input int lane, input logic [7:0] d);
    logic [31:0] r;
    logic [7:0]  lv;
    int          s;
    lv = w[lane*8 +: 8];
    s  = int'($signed(lv)) + int'($signed(d));
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    r = w;
    r[lane*8 +: 8] = s[7:0];
    return r;
  endfunction

  task automatic preload(input int a, input logic [31:0] d);
    tb_we = 1'b1; tb_a = 6'(a); tb_d = d;
    @(negedge clk);
    tb_we = 1'b0;
    model[a] = d;
  endtask

  task automatic do_read(input int a, output int wait_cyc);
    logic ok;
    int   k;
    ok = 1'b0;
    cif.rd_req = 1'b1; cif.rd_addr = 6'(a);
    for (k = 0; k < 40; k++) begin
      #1;
      if (cif.rd_gnt) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    wait_cyc = k;
    check("rd_gnt_seen", 32'(ok), 32'd1);
    @(negedge clk);
    cif.rd_req = 1'b0;
    if (ok) begin
      #1;
      check("rd_valid", 32'(cif.rd_valid), 32'd1);
      check("rd_data", cif.rd_data, model[a]);
    end
  endtask

  task automatic do_update(input int a, input int lane, input logic [7:0] d, output logic [31:0] written);
    logic        ok;
    logic [31:0] exp;
    int          k;
    ok  = 1'b0;
    exp = model_upd(model[a], lane, d);
    cif.upd_req = 1'b1; cif.upd_addr = 6'(a); cif.upd_lane = 2'(lane); cif.upd_delta = d;
    for (k = 0; k < 40; k++) begin
      #1;
      if (cif.upd_ack) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("upd_ack_seen", 32'(ok), 32'd1);
    written = ram_di;
    if (ok) begin
      check("upd_latency", 32'(k), 32'd1);
      check("upd_we", 32'(ram_we), 32'd1);
      check("upd_addr", 32'(ram_a), 32'(a));
      check("upd_word", ram_di, exp);
      model[a] = exp;
    end
    @(negedge clk);
    cif.upd_req = 1'b0;
  endtask

  initial begin
    int          w;
    int          bad;
    int          n_done;
    int          n_gnt;
    int          k;
    logic        ok;
    logic [31:0] wr;
    logic [31:0] exp;
    logic [7:0]  dl;

    rst_n = 1'b0;
    tb_we = 1'b0; tb_a = '0; tb_d = '0;
    cif.rd_req = 1'b1; cif.rd_addr = 6'd3;
    cif.upd_req = 1'b0; cif.upd_addr = '0; cif.upd_lane = '0; cif.upd_delta = '0;
    cif.clr_req = 1'b0;
    for (int i = 0; i < 64; i++) model[i] = 'x;

    repeat (3) @(negedge clk);
    #1;
    check("rst_rd_gnt", 32'(cif.rd_gnt), 32'd0);
    check("rst_rd_valid", 32'(cif.rd_valid), 32'd0);
    check("rst_rd_data", cif.rd_data, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ram_we", 32'(ram_we), 32'd0);
    check("rst_dpra", 32'(ram_dpra), 32'd0);
    cif.rd_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed: read latency, saturation corners, RMW then same-address read
    preload(5, 32'h1122_3344);
    do_read(5, w);
    check("t1_grant_cycle", 32'(w), 32'd0);

    preload(7, 32'h7F00_0000);
    do_update(7, 3, 8'd5, wr);
    check("t2_sat_hi", wr, 32'h7F00_0000);
    preload(7, 32'h0000_0080);
    do_update(7, 0, 8'hFF, wr);
    check("t2_sat_lo", wr, 32'h0000_0080);

    preload(2, 32'h0000_0010);
    do_update(2, 1, 8'h20, wr);
    check("t3_word", wr, 32'h0000_2010);
    do_read(2, w);
    check("t3_read_grant", 32'(w), 32'd0);

    // Random traffic against the word model, with lanes biased to the rails
    for (int i = 0; i < 64; i++) begin
      exp = $urandom;
      if ($urandom_range(0, 3) == 0) exp[7:0]   = 8'h7E;
      if ($urandom_range(0, 3) == 0) exp[31:24] = 8'h81;
      preload(i, exp);
    end
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 4))
        0: dl = 8'h7F;
        1: dl = 8'h80;
        2: dl = 8'hFF;
        default: dl = 8'($urandom);
      endcase
      if ($urandom_range(0, 1) == 0) do_read($urandom_range(0, 63), w);
      else do_update($urandom_range(0, 63), $urandom_range(0, 3), dl, wr);
    end

    // Starvation: reads held continuously alongside a pending update
    exp = model_upd(model[12], 2, 8'h05);
    cif.rd_req = 1'b1; cif.rd_addr = 6'd10;
    cif.upd_req = 1'b1; cif.upd_addr = 6'd12; cif.upd_lane = 2'd2; cif.upd_delta = 8'h05;
    n_gnt = 0; ok = 1'b0;
    for (k = 0; k < 40; k++) begin
      #1;
      if (cif.rd_gnt) n_gnt++;
      if (cif.upd_ack) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("starve_ack_seen", 32'(ok), 32'd1);
    check("starve_grants", 32'(n_gnt), 32'd4);
    check("starve_ack_cycle", 32'(k), 32'd5);
    check("starve_word", ram_di, exp);
    model[12] = exp;
    @(negedge clk);
    cif.upd_req = 1'b0;
    #1;
    check("starve_reads_resume", 32'(cif.rd_gnt), 32'd1);
    @(negedge clk);
    cif.rd_req = 1'b0;
    #1;
    check("starve_rd_data", cif.rd_data, model[10]);
    do_read(12, w);

    // Full clear sweep with a read pending throughout
    @(negedge clk);
    cif.clr_req = 1'b1; cif.rd_req = 1'b1; cif.rd_addr = 6'd9;
    #1;
    check("clr_rd_blocked", 32'(cif.rd_gnt), 32'd0);
    bad = 0; n_done = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      #1;
      if (!(ram_we && ram_a == 6'(i) && ram_di == 32'd0 && busy && !cif.rd_gnt)) bad++;
      if (cif.clr_done) begin
        n_done++;
        if (i != 63) bad++;
      end
    end
    check("clr_sweep_bad", 32'(bad), 32'd0);
    check("clr_done_count", 32'(n_done), 32'd1);
    for (int i = 0; i < 64; i++) model[i] = 32'd0;
    @(negedge clk);
    cif.clr_req = 1'b0;
    #1;
    check("clr_then_read", 32'(cif.rd_gnt), 32'd1);
    check("clr_idle", 32'(busy), 32'd0);
    @(negedge clk);
    cif.rd_req = 1'b0;
    #1;
    check("clr_rd_data", cif.rd_data, 32'd0);
    do_read($urandom_range(0, 63), w);

    // Reset in the middle of a sweep abandons it
    for (int i = 0; i < 64; i++) preload(i, $urandom | 32'h0100_0000);
    cif.clr_req = 1'b1;
    ok = 1'b0;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (ram_we && ram_a == 6'd20) begin ok = 1'b1; break; end
    end
    check("rst_mid_reach20", 32'(ok), 32'd1);
    rst_n = 1'b0;
    cif.clr_req = 1'b0;
    #1;
    check("rst_mid_we", 32'(ram_we), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_done", 32'(cif.clr_done), 32'd0);
    check("rst_mid_rd_valid", 32'(cif.rd_valid), 32'd0);
    for (int i = 0; i < 20; i++) model[i] = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("rst_no_resume", 32'(busy), 32'd0);
    do_read(0, w);
    do_read(19, w);
    do_read(20, w);
    do_read(21, w);
    do_read(40, w);
    do_read(63, w);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
